// File: rtl/svm_dt_pkg.sv
// svm_dt_pkg: shared phase-state encoding and constants for the dead-time stage.
package svm_dt_pkg;
   typedef enum logic [2:0] {DT_OFF, DT_LO, DT_RISE, DT_HI, DT_FALL} dt_state_t;
   localparam int DT_MIN = 1;
endpackage

// File: rtl/svm_dt_phase.sv
// svm_dt_phase: one phase leg, complementary gates with a dead band on every transition.
module svm_dt_phase
   import svm_dt_pkg::*;
#(
   parameter int DT_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rstb,
   input  logic                pwm_i,
   input  logic [DT_WIDTH-1:0] dt_i,
   input  logic                force_off_i,
   input  logic                start_i,
   output logic                hi_o,
   output logic                lo_o,
   output logic                on_d_o
);
   dt_state_t state_q, state_d;
   logic [DT_WIDTH-1:0] cnt_q, cnt_d;
   logic done;
   assign done = cnt_q == DT_WIDTH'(1);
   assign on_d_o = state_d != DT_OFF;
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      if (force_off_i) state_d = DT_OFF;
      else case (state_q)
         DT_OFF:  if (start_i) begin state_d = DT_FALL; cnt_d = dt_i; end
         DT_LO:   if (pwm_i) begin state_d = DT_RISE; cnt_d = dt_i; end
         DT_RISE: if (!pwm_i) state_d = DT_LO;
                  else if (done) state_d = DT_HI;
                  else cnt_d = cnt_q - DT_WIDTH'(1);
         DT_HI:   if (!pwm_i) begin state_d = DT_FALL; cnt_d = dt_i; end
         DT_FALL: if (pwm_i) state_d = DT_HI;
                  else if (done) state_d = DT_LO;
                  else cnt_d = cnt_q - DT_WIDTH'(1);
         default: state_d = DT_OFF;
      endcase
   end
   // Gates come straight from flops so the pins never see decode glitches.
   always_ff @(posedge clk or negedge rstb)
      if (!rstb) begin
         state_q <= DT_OFF;
         cnt_q <= '0;
         hi_o <= 1'b0;
         lo_o <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         hi_o <= state_d == DT_HI;
         lo_o <= state_d == DT_LO;
      end
endmodule

// File: rtl/svm_deadtime.sv
// svm_deadtime: three-phase gate drive with dead time, fault latch and enable gating.
module svm_deadtime
   import svm_dt_pkg::*;
#(
   parameter int DT_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rstb,
   input  logic                pwmA,
   input  logic                pwmB,
   input  logic                pwmC,
   input  logic                halt,
   input  logic [DT_WIDTH-1:0] dead_time,
   input  logic                enable,
   input  logic                fault,
   input  logic                fault_clr,
   output logic                gA_hi,
   output logic                gA_lo,
   output logic                gB_hi,
   output logic                gB_lo,
   output logic                gC_hi,
   output logic                gC_lo,
   output logic                fault_latched,
   output logic                active
);
   logic [2:0] pwm_q, hi, lo, on_d;
   logic halt_q, fault_latched_q, fault_latched_d, active_q, force_off, start;
   logic [DT_WIDTH-1:0] dt_q, dt_d;
   assign force_off = fault | ~enable;
   assign start = enable & ~fault_latched_q & halt_q;
   // New dead time only lands on a carrier boundary; running bands keep their count.
   assign dt_d = halt_q ? (dead_time < DT_WIDTH'(DT_MIN) ? DT_WIDTH'(DT_MIN) : dead_time) : dt_q;
   assign fault_latched_d = fault | (fault_latched_q & ~fault_clr);
   always_ff @(posedge clk or negedge rstb)
      if (!rstb) begin
         pwm_q <= '0;
         halt_q <= 1'b0;
         dt_q <= '1;
         fault_latched_q <= 1'b0;
         active_q <= 1'b0;
      end else begin
         pwm_q <= {pwmC, pwmB, pwmA};
         halt_q <= halt;
         dt_q <= dt_d;
         fault_latched_q <= fault_latched_d;
         active_q <= |on_d;
      end
   for (genvar g = 0; g < 3; g++) begin : g_ph
      svm_dt_phase #(.DT_WIDTH(DT_WIDTH)) u_ph (
         .clk(clk), .rstb(rstb), .pwm_i(pwm_q[g]), .dt_i(dt_q),
         .force_off_i(force_off), .start_i(start),
         .hi_o(hi[g]), .lo_o(lo[g]), .on_d_o(on_d[g])
      );
   end
   assign {gC_hi, gB_hi, gA_hi} = hi;
   assign {gC_lo, gB_lo, gA_lo} = lo;
   assign fault_latched = fault_latched_q;
   assign active = active_q;
endmodule

// File: tb/tb_svm_deadtime.sv
// tb_svm_deadtime: directed plus random stimulus against a side/timestamp reference model.
module tb_svm_deadtime;
   logic clk = 1'b0, rstb = 1'b0;
   logic pwmA = 0, pwmB = 0, pwmC = 0, halt = 0, enable = 0, fault = 0, fault_clr = 0;
   logic [7:0] dead_time = 8'd0;
   logic gA_hi, gA_lo, gB_hi, gB_lo, gC_hi, gC_lo, fault_latched, active;
   int n_vec = 0, n_err = 0;
   // Model: per phase, driven side (0 none, 1 lo, 2 hi), last committed side, band end time.
   int run[3], drv[3], com[3], band_end[3];
   logic [2:0] m_pwm;
   logic m_halt, m_latch;
   int m_dt, t;

   svm_deadtime #(.DT_WIDTH(8)) dut (
      .clk(clk), .rstb(rstb), .pwmA(pwmA), .pwmB(pwmB), .pwmC(pwmC), .halt(halt),
      .dead_time(dead_time), .enable(enable), .fault(fault), .fault_clr(fault_clr),
      .gA_hi(gA_hi), .gA_lo(gA_lo), .gB_hi(gB_hi), .gB_lo(gB_lo), .gC_hi(gC_hi), .gC_lo(gC_lo),
      .fault_latched(fault_latched), .active(active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 3; i++) begin run[i] = 0; drv[i] = 0; com[i] = 0; band_end[i] = 0; end
      m_pwm = '0; m_halt = 0; m_latch = 0; m_dt = 255;
   endtask

   task automatic m_step();
      int want;
      for (int i = 0; i < 3; i++) begin
         want = m_pwm[i] ? 2 : 1;
         if (fault || !enable) begin run[i] = 0; drv[i] = 0; end
         else if (run[i] == 0) begin
            if (!m_latch && m_halt) begin run[i] = 1; drv[i] = 0; com[i] = 2; band_end[i] = t + m_dt; end
         end else if (drv[i] != want) begin
            if (drv[i] != 0) begin drv[i] = 0; band_end[i] = t + m_dt; end
            else if (want == com[i] || t >= band_end[i]) begin drv[i] = want; com[i] = want; end
         end
      end
      if (m_halt) m_dt = (dead_time == 0) ? 1 : int'(dead_time);
      m_latch = fault ? 1'b1 : (fault_clr ? 1'b0 : m_latch);
      m_pwm = {pwmC, pwmB, pwmA};
      m_halt = halt;
      t++;
   endtask

   function automatic logic [7:0] m_out();
      logic [7:0] v;
      for (int i = 0; i < 3; i++) v[7-2*i -: 2] = {drv[i] == 2, drv[i] == 1};
      v[1] = m_latch;
      v[0] = (run[0] | run[1] | run[2]) != 0;
      return v;
   endfunction

   function automatic logic [7:0] dut_out();
      return {gA_hi, gA_lo, gB_hi, gB_lo, gC_hi, gC_lo, fault_latched, active};
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         m_step();
         @(negedge clk);
         chk("outs", 32'(dut_out()), 32'(m_out()));
         chk("overlap", 32'((gA_hi & gA_lo) | (gB_hi & gB_lo) | (gC_hi & gC_lo)), 32'd0);
      end
   endtask

   task automatic pulse_halt();
      halt = 1;
      cyc(1);
      halt = 0;
   endtask

   initial begin
      t = 0;
      m_reset();
      repeat (3) @(negedge clk);
      chk("reset", 32'(dut_out()), 32'd0);
      rstb = 1;
      // Load dead time 4 while disabled, then start on a boundary.
      dead_time = 8'd4;
      pulse_halt();
      cyc(2);
      enable = 1;
      halt = 1;
      for (int i = 1; i <= 7; i++) begin
         cyc(1);
         halt = 0;
         chk("t1_lo", 32'(gA_lo), 32'(i >= 6));
         chk("t1_hi", 32'(gA_hi), 32'd0);
         chk("t1_act", 32'(active), 32'(i >= 2));
      end
      pwmA = 1;
      for (int i = 1; i <= 8; i++) begin
         cyc(1);
         chk("t2_lo", 32'(gA_lo), 32'(i < 2));
         chk("t2_hi", 32'(gA_hi), 32'(i >= 6));
      end
      pwmA = 0;
      for (int i = 1; i <= 8; i++) begin
         cyc(1);
         chk("t2r_hi", 32'(gA_hi), 32'(i < 2));
         chk("t2r_lo", 32'(gA_lo), 32'(i >= 6));
      end
      // Short pwmB pulse is absorbed inside a 6-cycle band.
      dead_time = 8'd6;
      pulse_halt();
      cyc(3);
      pwmB = 1;
      for (int i = 1; i <= 12; i++) begin
         cyc(1);
         if (i == 2) pwmB = 0;
         chk("t3_hi", 32'(gB_hi), 32'd0);
         chk("t3_lo", 32'(gB_lo), 32'(!(i == 2 || i == 3)));
      end
      // dead_time 0 acts as 1; a later change waits for the next boundary.
      dead_time = 8'd0;
      pulse_halt();
      cyc(3);
      pwmC = 1;
      for (int i = 1; i <= 4; i++) begin
         cyc(1);
         chk("t4_hi", 32'(gC_hi), 32'(i >= 3));
      end
      dead_time = 8'd10;
      pwmC = 0;
      for (int i = 1; i <= 4; i++) begin
         cyc(1);
         chk("t4_lo", 32'(gC_lo), 32'(i >= 3));
      end
      pulse_halt();
      cyc(3);
      pwmC = 1;
      for (int i = 1; i <= 14; i++) begin
         cyc(1);
         chk("t4_hi10", 32'(gC_hi), 32'(i >= 12));
      end
      // Fault while gC_hi is on.
      fault = 1;
      cyc(1);
      chk("t5_gates", 32'(dut_out() >> 2), 32'd0);
      chk("t5_latch", 32'(fault_latched), 32'd1);
      fault_clr = 1;
      cyc(1);
      chk("t5_clr_ign", 32'(fault_latched), 32'd1);
      fault = 0;
      cyc(1);
      chk("t5_clr", 32'(fault_latched), 32'd0);
      fault_clr = 0;
      pwmC = 0;
      cyc(3);
      chk("t5_still_off", 32'(dut_out() >> 2), 32'd0);
      pulse_halt();
      cyc(14);
      chk("t5_relo", 32'(gC_lo), 32'd1);
      // Random run.
      for (int n = 0; n < 10000; n++) begin
         if ($urandom_range(0, 7) == 0) pwmA = ~pwmA;
         if ($urandom_range(0, 7) == 0) pwmB = ~pwmB;
         if ($urandom_range(0, 5) == 0) pwmC = ~pwmC;
         halt = (n % 32) == 0;
         if ($urandom_range(0, 99) == 0) dead_time = 8'($urandom_range(0, 12));
         enable = $urandom_range(0, 299) != 0;
         fault = $urandom_range(0, 799) == 0;
         fault_clr = $urandom_range(0, 39) == 0;
         cyc(1);
      end
      // Asynchronous reset mid-operation.
      fault = 0;
      fault_clr = 0;
      enable = 1;
      halt = 0;
      #2 rstb = 0;
      #1 chk("async_rst", 32'(dut_out()), 32'd0);
      m_reset();
      @(negedge clk);
      rstb = 1;
      cyc(5);
      pulse_halt();
      cyc(20);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/svm_deadtime.md
Name: svm_deadtime

Overview:
- Downstream stage of the SVM triangle-compare modulator. Consumes the three raw phase PWM levels (pwmA/B/C) and the period-boundary strobe (halt).
- Produces complementary high-side and low-side gate drives per phase, with programmable dead time inserted on every transition.
- Provides a latched fault shutdown and an enable gate. Outputs are the final signals to the gate-driver pins.

Parameters:
DT_WIDTH, 8, width of the dead-time count in clk cycles

Ports:
clk  in  1  system clock; all logic on posedge
rstb  in  1  reset, asynchronous, active-low
pwmA  in  1  raw phase-A PWM from modulator (launched on negedge, sampled on posedge)
pwmB  in  1  raw phase-B PWM
pwmC  in  1  raw phase-C PWM
halt  in  1  modulator period boundary (carrier counter == 0)
dead_time  in  DT_WIDTH  requested dead time in cycles; 0 is treated as 1
enable  in  1  1 = allow switching; 0 = force all gates off
fault  in  1  external fault; synchronous, level
fault_clr  in  1  clears the latched fault
gA_hi, gA_lo, gB_hi, gB_lo, gC_hi, gC_lo  out  1 each  gate drives, registered
fault_latched  out  1  sticky fault flag
active  out  1  at least one phase is not in OFF

Behaviour:
- Reset values: all six gates 0, fault_latched 0, active 0, every phase in OFF, dt_reg all-ones, pwm_q 0, halt_q 0.
- Input registration: pwm_q[2:0] and halt_q are the posedge-registered copies of pwmA/B/C and halt; FSMs act only on these.
- dt_reg: loads max(dead_time,1) on any cycle with halt_q=1. It is otherwise held. A running dead-band counter is never reloaded by a dt_reg change.
- Per-phase FSM; gates decode directly from registered state:
  - OFF: hi=0, lo=0.
    - Exit to FALL (counter <= dt_reg) when enable & !fault_latched & halt_q.
  - LO: hi=0, lo=1.
    - pwm_q=1 -> RISE, counter <= dt_reg.
  - RISE: hi=0, lo=0; counter decrements each cycle.
    - pwm_q=0 -> LO immediately (glitch absorbed; high side was never on).
    - Else counter==1 -> HI.
  - HI: hi=1, lo=0.
    - pwm_q=0 -> FALL, counter <= dt_reg.
  - FALL: hi=0, lo=0.
    - pwm_q=1 -> HI immediately.
    - Else counter==1 -> LO.
- Timing: for a pwm edge sampled into pwm_q at posedge k, the on-gate drops at edge k+1. The opposite gate asserts at edge k+1+dt_reg. The both-off window is exactly dt_reg cycles.
- Priority, highest first, applied to all phases in the same edge:
  1. fault_q: fault sampled 1 -> all phases OFF and fault_latched <= 1.
  2. enable=0 -> all phases OFF, no latch.
  3. Normal FSM.
- fault_latched: cleared only by fault_clr=1 with fault=0 on the same edge. fault=1 wins over fault_clr.
- Leaving OFF requires a halt_q boundary, so phases restart aligned to the carrier.
- Invariant: hi & lo is never 1 for any phase in any cycle, including reset release, fault, and enable toggling mid-dead-band.
- active = OR over phases of (state != OFF), registered with the state.
- Asynchronous reset mid-operation: gates go to 0 immediately. No output glitch on release, because OFF exit needs enable and halt_q.

Decomposition:
- Package svm_dt_pkg holds:
  - enum dt_state_t {DT_OFF, DT_LO, DT_RISE, DT_HI, DT_FALL}
  - localparam DT_MIN = 1
- Sub-module svm_dt_phase: one FSM plus DT_WIDTH down-counter, taking pwm_q, dt_reg, force_off, start. It is instantiated three times.
- The top level owns input registers, dt_reg, fault latch and active.

Test Plan:
1. Reset release, enable=1, dead_time=4, halt pulse, pwmA held 0 -> gA_lo rises 4 cycles after FALL entry. gA_hi stays 0. active=1.
2. From LO, pwmA 0->1 sampled at edge k -> gA_lo=0 at k+1, gA_hi=1 at k+5. Reverse edge gives the symmetric 4-cycle gap.
3. pwmB high pulse of 2 cycles with dead_time=6 -> gB_hi never asserts. gB_lo returns 1 one cycle after pwm_q falls, with no overlap.
4. dead_time=0 -> effective gap of 1 cycle. Changing dead_time to 10 mid-period takes effect only after the next halt.
5. fault=1 while gC_hi=1 -> all gates 0 on the next edge and fault_latched=1. fault_clr with fault=1 is ignored. Clearing with fault=0 still keeps gates 0 until enable & halt, then FALL -> LO.
6. Randomised pwm on three phases for 10k cycles with random enable/fault -> assertion: no hi&lo overlap. Every hi/lo transition is separated by ≥ dt_reg cycles of both-off, unless a glitch was absorbed back to the same side.
